control_sequencer: RTL and testbench

- Hardwired Moore control unit for the miniSRC datapath.
- Sits directly upstream of the CPU datapath and replaces the hand-driven control stimulus currently supplied by benches.
- Samples IR and CON_FF and steps a T-state sequencer: fetch (T0–T2), decode, then an execute microsequence per instruction class.
- Drives every datapath control strobe and the 5-bit ALU opcode.

---
 rtl/control_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the miniSRC datapath: fetch T0-T2, decode, per-class execute microsequence.
// Ports: clock/clear (sync active-low), ir[31:27] opcode, CONFF_out branch flag; all datapath strobes, 5-bit ALU opcode, run.
// Optional MEM_WAIT_EN adds mem_ready: memory states (T1, ld T6, st T7) hold until it is sampled high.
module control_sequencer #(
  parameter logic [4:0] ALU_NOP = 5'b11010,
  parameter logic [4:0] ALU_ADD = 5'b00011
) (
`ifdef MEM_WAIT_EN
  input  logic        mem_ready,
`endif
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        CONFF_out,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        IncPC,
  output logic        PCin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIout,
  output logic        HIin,
  output logic        LOout,
  output logic        LOin,
  output logic        Cout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        Zin,
  output logic        MDRout,
  output logic        MDRin,
  output logic        MARin,
  output logic        memRead,
  output logic        memWrite,
  output logic        inPort_en,
  output logic        outPort_en,
  output logic        inPortOut,
  output logic        CONin,
  output logic [4:0]  opcode,
  output logic        run
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  // Instruction classes; anything unrecognised behaves as nop.
  localparam logic [3:0] C_NOP  = 4'd0;
  localparam logic [3:0] C_LD   = 4'd1;
  localparam logic [3:0] C_LDI  = 4'd2;
  localparam logic [3:0] C_ST   = 4'd3;
  localparam logic [3:0] C_ALUR = 4'd4;
  localparam logic [3:0] C_ALUI = 4'd5;
  localparam logic [3:0] C_BR   = 4'd6;
  localparam logic [3:0] C_IN   = 4'd7;
  localparam logic [3:0] C_OUT  = 4'd8;
  localparam logic [3:0] C_HALT = 4'd9;

  typedef struct packed {
    logic gra, grb, grc, rin, rout, baout, pcout, incpc, pcin, irin, yin, cout;
    logic zlowout, zin, mdrout, mdrin, marin, mem_read, mem_write;
    logic inport_en, outport_en, inport_out, conin;
    logic [4:0] alu_op;
    logic       run;
  } ctl_t;

  function automatic logic [3:0] op_class(input logic [4:0] op);
    case (op)
      5'b00000:                   return C_LD;
      5'b00001:                   return C_LDI;
      5'b00010:                   return C_ST;
      5'b00011, 5'b00100,
      5'b00101, 5'b00110:         return C_ALUR;
      5'b01100, 5'b01101, 5'b01110: return C_ALUI;
      5'b10010:                   return C_BR;
      5'b10110:                   return C_IN;
      5'b10111:                   return C_OUT;
      5'b11011:                   return C_HALT;
      default:                    return C_NOP;
    endcase
  endfunction

  logic [3:0] state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [3:0] cls_d;
  ctl_t       ctl_q, ctl_d;
  logic       mem_go;
  logic       unused_ir;

  assign unused_ir = ^ir[26:0];

`ifdef MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  // The opcode is captured on the T2->T3 edge so later states never look at ir again.
  always_comb begin
    op_d    = (state_q == S_T2) ? ir[31:27] : op_q;
    cls_d   = op_class(op_d);
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_go) state_d = S_T2;
      S_T2: begin
        if (cls_d == C_HALT)     state_d = S_HALT;
        else if (cls_d == C_NOP) state_d = S_T0;
        else                     state_d = S_T3;
      end
      S_T3:   state_d = (cls_d == C_IN || cls_d == C_OUT) ? S_T0 : S_T4;
      S_T4:   state_d = S_T5;
      S_T5:   state_d = (cls_d == C_LD || cls_d == C_ST || cls_d == C_BR) ? S_T6 : S_T0;
      S_T6: begin
        if (cls_d == C_BR)       state_d = S_T0;
        else if (cls_d == C_ST)  state_d = S_T7;
        else if (mem_go)         state_d = S_T7;
      end
      S_T7:   if (cls_d != C_ST || mem_go) state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so each one is
  // high for exactly the cycle the state register holds that Tn.
  always_comb begin
    ctl_d        = '0;
    ctl_d.alu_op = ALU_NOP;
    ctl_d.run    = 1'b1;
    case (state_d)
      S_T0: begin ctl_d.pcout = 1'b1; ctl_d.marin = 1'b1; ctl_d.incpc = 1'b1; ctl_d.zin = 1'b1; end
      S_T1: begin ctl_d.zlowout = 1'b1; ctl_d.pcin = 1'b1; ctl_d.mem_read = 1'b1; ctl_d.mdrin = 1'b1; end
      S_T2: begin ctl_d.mdrout = 1'b1; ctl_d.irin = 1'b1; end
      S_T3: begin
        case (cls_d)
          C_LD, C_LDI, C_ST: begin ctl_d.grb = 1'b1; ctl_d.baout = 1'b1; ctl_d.yin = 1'b1; end
          C_ALUR, C_ALUI:    begin ctl_d.grb = 1'b1; ctl_d.rout = 1'b1; ctl_d.yin = 1'b1; end
          C_BR:              begin ctl_d.gra = 1'b1; ctl_d.rout = 1'b1; ctl_d.conin = 1'b1; end
          C_IN:              begin ctl_d.inport_out = 1'b1; ctl_d.gra = 1'b1; ctl_d.rin = 1'b1; end
          C_OUT:             begin ctl_d.gra = 1'b1; ctl_d.rout = 1'b1; ctl_d.outport_en = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls_d)
          C_LD, C_LDI, C_ST: begin ctl_d.cout = 1'b1; ctl_d.alu_op = ALU_ADD; ctl_d.zin = 1'b1; end
          C_ALUR:            begin ctl_d.grc = 1'b1; ctl_d.rout = 1'b1; ctl_d.alu_op = op_d; ctl_d.zin = 1'b1; end
          C_ALUI: begin
            ctl_d.cout = 1'b1;
            ctl_d.zin  = 1'b1;
            // Immediate forms reuse the register-form ALU codes.
            case (op_d)
              5'b01100: ctl_d.alu_op = 5'b00011;
              5'b01101: ctl_d.alu_op = 5'b00101;
              default:  ctl_d.alu_op = 5'b00110;
            endcase
          end
          C_BR:              begin ctl_d.pcout = 1'b1; ctl_d.yin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls_d)
          C_LD, C_ST:              begin ctl_d.zlowout = 1'b1; ctl_d.marin = 1'b1; end
          C_LDI, C_ALUR, C_ALUI:   begin ctl_d.zlowout = 1'b1; ctl_d.gra = 1'b1; ctl_d.rin = 1'b1; end
          C_BR:                    begin ctl_d.cout = 1'b1; ctl_d.alu_op = ALU_ADD; ctl_d.zin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls_d)
          C_LD: begin ctl_d.mem_read = 1'b1; ctl_d.mdrin = 1'b1; end
          C_ST: begin ctl_d.gra = 1'b1; ctl_d.rout = 1'b1; ctl_d.mdrin = 1'b1; end
          // Branch not taken keeps the cycle but drives nothing.
          C_BR: if (CONFF_out) begin ctl_d.zlowout = 1'b1; ctl_d.pcin = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        if (cls_d == C_ST) ctl_d.mem_write = 1'b1;
        else begin ctl_d.mdrout = 1'b1; ctl_d.gra = 1'b1; ctl_d.rin = 1'b1; end
      end
      S_HALT: ctl_d.run = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q      <= S_IDLE;
      op_q         <= ALU_NOP;
      ctl_q        <= '0;
      ctl_q.alu_op <= ALU_NOP;
      ctl_q.run    <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctl_q   <= ctl_d;
    end
  end

  assign Gra        = ctl_q.gra;
  assign Grb        = ctl_q.grb;
  assign Grc        = ctl_q.grc;
  assign Rin        = ctl_q.rin;
  assign Rout       = ctl_q.rout;
  assign BAout      = ctl_q.baout;
  assign PCout      = ctl_q.pcout;
  assign IncPC      = ctl_q.incpc;
  assign PCin       = ctl_q.pcin;
  assign IRin       = ctl_q.irin;
  assign Yin        = ctl_q.yin;
  assign Cout       = ctl_q.cout;
  assign Zlowout    = ctl_q.zlowout;
  assign Zin        = ctl_q.zin;
  assign MDRout     = ctl_q.mdrout;
  assign MDRin      = ctl_q.mdrin;
  assign MARin      = ctl_q.marin;
  assign memRead    = ctl_q.mem_read;
  assign memWrite   = ctl_q.mem_write;
  assign inPort_en  = ctl_q.inport_en;
  assign outPort_en = ctl_q.outport_en;
  assign inPortOut  = ctl_q.inport_out;
  assign CONin      = ctl_q.conin;
  assign opcode     = ctl_q.alu_op;
  assign run        = ctl_q.run;

  // Reserved for mul/div in a later revision.
  assign HIout    = 1'b0;
  assign HIin     = 1'b0;
  assign LOout    = 1'b0;
  assign LOin     = 1'b0;
  assign Zhighout = 1'b0;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
  localparam logic [4:0] ALU_NOP = 5'b11010;
  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef struct packed {
    logic gra, grb, grc, rin, rout, baout, pcout, incpc, pcin, irin, yin;
    logic hiout, hiin, loout, loin, cout, zhighout, zlowout, zin;
    logic mdrout, mdrin, marin, memread, memwrite;
    logic inport_en, outport_en, inportout, conin;
    logic [4:0] opcode;
    logic       run;
  } vec_t;

  logic clock = 1'b0;
  logic clear;
  logic [31:0] ir;
  logic conff;
`ifdef MEM_WAIT_EN
  logic mem_ready = 1'b1;
`endif
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, IncPC, PCin, IRin, Yin;
  logic HIout, HIin, LOout, LOin, Cout, Zhighout, Zlowout, Zin;
  logic MDRout, MDRin, MARin, memRead, memWrite;
  logic inPort_en, outPort_en, inPortOut, CONin, run;
  logic [4:0] opcode;

  always #5 clock = ~clock;

  control_sequencer dut (
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .clock(clock), .clear(clear), .ir(ir), .CONFF_out(conff),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .IRin(IRin), .Yin(Yin),
    .HIout(HIout), .HIin(HIin), .LOout(LOout), .LOin(LOin), .Cout(Cout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .Zin(Zin),
    .MDRout(MDRout), .MDRin(MDRin), .MARin(MARin), .memRead(memRead), .memWrite(memWrite),
    .inPort_en(inPort_en), .outPort_en(outPort_en), .inPortOut(inPortOut), .CONin(CONin),
    .opcode(opcode), .run(run)
  );

  vec_t act;
  assign act = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, IncPC, PCin, IRin, Yin,
                HIout, HIin, LOout, LOin, Cout, Zhighout, Zlowout, Zin,
                MDRout, MDRin, MARin, memRead, memWrite,
                inPort_en, outPort_en, inPortOut, CONin, opcode, run};

  vec_t exp_q[$];
  vec_t stage_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   started = 1'b0;

  function automatic vec_t base_vec();
    vec_t b;
    b = '0;
    b.opcode = ALU_NOP;
    b.run = 1'b1;
    return b;
  endfunction

  // Reference: per-cycle strobe sets of one instruction, straight from the microcode tables.
  task automatic build(input logic [31:0] instr, input logic cf);
    vec_t b, e;
    logic [4:0] op;
    op = instr[31:27];
    b = base_vec();
    stage_q.delete();
    e = b; e.pcout = 1'b1; e.marin = 1'b1; e.incpc = 1'b1; e.zin = 1'b1; stage_q.push_back(e);
    e = b; e.zlowout = 1'b1; e.pcin = 1'b1; e.memread = 1'b1; e.mdrin = 1'b1; stage_q.push_back(e);
    e = b; e.mdrout = 1'b1; e.irin = 1'b1; stage_q.push_back(e);
    case (op)
      5'b00000, 5'b00001, 5'b00010: begin
        e = b; e.grb = 1'b1; e.baout = 1'b1; e.yin = 1'b1; stage_q.push_back(e);
        e = b; e.cout = 1'b1; e.opcode = ALU_ADD; e.zin = 1'b1; stage_q.push_back(e);
        if (op == 5'b00001) begin
          e = b; e.zlowout = 1'b1; e.gra = 1'b1; e.rin = 1'b1; stage_q.push_back(e);
        end else begin
          e = b; e.zlowout = 1'b1; e.marin = 1'b1; stage_q.push_back(e);
          if (op == 5'b00000) begin
            e = b; e.memread = 1'b1; e.mdrin = 1'b1; stage_q.push_back(e);
            e = b; e.mdrout = 1'b1; e.gra = 1'b1; e.rin = 1'b1; stage_q.push_back(e);
          end else begin
            e = b; e.gra = 1'b1; e.rout = 1'b1; e.mdrin = 1'b1; stage_q.push_back(e);
            e = b; e.memwrite = 1'b1; stage_q.push_back(e);
          end
        end
      end
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100, 5'b01101, 5'b01110: begin
        e = b; e.grb = 1'b1; e.rout = 1'b1; e.yin = 1'b1; stage_q.push_back(e);
        e = b; e.zin = 1'b1;
        if (op[3]) begin
          e.cout = 1'b1;
          e.opcode = (op == 5'b01100) ? 5'b00011 : (op == 5'b01101) ? 5'b00101 : 5'b00110;
        end else begin
          e.grc = 1'b1; e.rout = 1'b1; e.opcode = op;
        end
        stage_q.push_back(e);
        e = b; e.zlowout = 1'b1; e.gra = 1'b1; e.rin = 1'b1; stage_q.push_back(e);
      end
      5'b10010: begin
        e = b; e.gra = 1'b1; e.rout = 1'b1; e.conin = 1'b1; stage_q.push_back(e);
        e = b; e.pcout = 1'b1; e.yin = 1'b1; stage_q.push_back(e);
        e = b; e.cout = 1'b1; e.opcode = ALU_ADD; e.zin = 1'b1; stage_q.push_back(e);
        e = b; if (cf) begin e.zlowout = 1'b1; e.pcin = 1'b1; end stage_q.push_back(e);
      end
      5'b10110: begin e = b; e.inportout = 1'b1; e.gra = 1'b1; e.rin = 1'b1; stage_q.push_back(e); end
      5'b10111: begin e = b; e.gra = 1'b1; e.rout = 1'b1; e.outport_en = 1'b1; stage_q.push_back(e); end
      default: ;
    endcase
  endtask

  // Called #1 after the edge that starts T0; returns #1 after the edge that starts the next T0.
  task automatic run_instr(input logic [31:0] instr, input logic cf);
    int n;
    ir = instr;
    conff = cf;
    build(instr, cf);
    n = stage_q.size();
    foreach (stage_q[i]) exp_q.push_back(stage_q[i]);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic restart_from_reset(input int edges);
    for (int k = 0; k < edges; k++) begin
      @(posedge clock); #1;
      exp_q.push_back(base_vec());
    end
    clear = 1'b1;
    @(posedge clock); #1;
  endtask

  // Monitor: one expected vector per cycle once the driver has started.
  always @(negedge clock) begin
    vec_t e;
    int drv;
    cyc++;
    if (started) begin
      drv = $countones({Rout, BAout, PCout, Zlowout, Zhighout, MDRout, Cout, inPortOut, HIout, LOout});
      checks++;
      if (drv > 1) begin
        errors++;
        $display("FAIL bus_drivers cycle %0d got %0d drivers want at most 1", cyc, drv);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ctl_underflow cycle %0d got %h want (no expectation queued)", cyc, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL ctl cycle %0d got %h want %h", cyc, act, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ops [15];
    logic [4:0] op;
    logic [31:0] r;
    vec_t h;
    ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b01100, 5'b01101, 5'b01110, 5'b10010, 5'b10110, 5'b10111, 5'b11010, 5'b11001};
    clear = 1'b0;
    ir = 32'h0;
    conff = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    started = 1'b1;
    exp_q.push_back(base_vec());
    clear = 1'b1;
    @(posedge clock); #1;

    run_instr(32'h00900065, 1'b0);
    run_instr(32'h19A28000, 1'b0);
    run_instr(32'h93000009, 1'b1);
    run_instr(32'h93000009, 1'b0);

    // halt: fetch, then 20 halted cycles, then restart through reset
    ir = 32'hD8000000;
    build(ir, 1'b0);
    foreach (stage_q[i]) exp_q.push_back(stage_q[i]);
    h = base_vec();
    h.run = 1'b0;
    repeat (20) exp_q.push_back(h);
    repeat (23) @(posedge clock);
    #1;
    exp_q.push_back(h);
    clear = 1'b0;
    restart_from_reset(2);

    // reset asserted during ld T5 aborts the sequence
    ir = 32'h00900065;
    build(ir, 1'b0);
    for (int i = 0; i < 6; i++) exp_q.push_back(stage_q[i]);
    repeat (5) @(posedge clock);
    #1;
    clear = 1'b0;
    restart_from_reset(1);

    for (int n = 0; n < 80; n++) begin
      r = $urandom();
      op = ($urandom_range(0, 1) == 1) ? ops[$urandom_range(0, 14)] : 5'($urandom_range(0, 31));
      if (op == 5'b11011) op = 5'b11010;
      run_instr({op, r[26:0]}, 1'($urandom_range(0, 1)));
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d queued want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
